calc2_req_sched: RTL and testbench
==================================

// Module: calc2_req_sched
// PURPOSE
//  Front-end scheduler for the calc2 shared ALU. Captures two-cycle requests (cmd+op1, then op2)
//  from NPORTS requester ports and queues them per port. Grants the single ALU round-robin and
//  routes ALU responses back to the originating port's out_resp/out_data/out_tag.
//  Sits between the top-level request pins and the ALU core inside calc2_top.
// PARAMETERS
//  NPORTS      4   number of requester ports
//  FIFO_DEPTH  4   request entries buffered per port (power of 2)
// PORTS
//  c_clk          in   1          single clock, all logic rising-edge
//  reset_n        in   1          asynchronous active-low reset
//  req_cmd_in     in   NPORTSx4   per-port command; nonzero = cycle 1 of a request
//  req_data_in    in   NPORTSx32  op1 in the cmd cycle, op2 in the following cycle
//  req_tag_in     in   NPORTSx2   request tag, sampled in the cmd cycle
//  alu_req_valid  out  1          issue valid
//  alu_req_ready  in   1          ALU accepts the issue this cycle
//  alu_req_cmd    out  4          issued command
//  alu_req_op1    out  32         issued operand 1
//  alu_req_op2    out  32         issued operand 2
//  alu_req_port   out  2          originating port id
//  alu_req_tag    out  2          originating tag
//  alu_rsp_valid  in   1          ALU result valid
//  alu_rsp_port   in   2          port id echoed by ALU
//  alu_rsp_tag    in   2          tag echoed by ALU
//  alu_rsp_resp   in   2          1 = ok, 2 = overflow/underflow
//  alu_rsp_data   in   32         result
//  out_resp       out  NPORTSx2   per-port response code; 0 = none
//  out_data       out  NPORTSx32  per-port result
//  out_tag        out  NPORTSx2   per-port tag
//  drop_pulse     out  NPORTS     1-cycle pulse: request dropped because the port FIFO was full
// BEHAVIOUR
//  Reset: all FIFOs empty, capture FSMs IDLE, rr pointer=0; every output 0.
//    Asserts asynchronously at any time, including mid-capture or mid-issue; all state is discarded.
//  Capture FSM (per port): IDLE --cmd!=0--> OP2 (latch cmd/op1/tag); OP2 --always--> IDLE.
//    In OP2, write {cmd,op1,op2=req_data_in,tag,err} to the FIFO.
//    The cmd value in the OP2 cycle is ignored (no back-to-back overlap).
//    err=1 if cmd is not in {1,2,5,6}.
//  FIFO full at the OP2 write: entry discarded, drop_pulse[p]=1 for that cycle, no response.
//  Arbitration: candidates are ports with a non-empty FIFO.
//    Grant goes to the first candidate at or after rr_ptr, wrapping NPORTS-1 -> 0.
//    On pop, rr_ptr <= granted+1 mod NPORTS; no pop -> pointer unchanged.
//  Issue (head err=0): alu_req_valid=1 with head fields, driven combinationally from FIFO head.
//    Pop only when valid&&ready. While !ready, all alu_req_* hold stable and the grant does not move.
//  Error entries (head err=1) never reach the ALU. When granted, pop and register
//    out_resp[p]=2, out_data[p]=0, out_tag[p]=tag.
//    If alu_rsp_valid targets the same port that cycle: no pop; retry next grant.
//  Response: alu_rsp_valid registers out_resp/out_data/out_tag[alu_rsp_port] = rsp fields for
//    exactly 1 cycle (1-cycle latency). Every other port and cycle drives 0.
//  Min latency: cmd at T, op2 at T+1, alu_req_valid at T+2 if granted; out_resp = ALU rsp cycle+1.
//  Simultaneous FIFO write (OP2) and pop on one port: both occur; a full FIFO with a same-cycle pop
//    is not full, so the write succeeds.
//  Per-port order is strict FIFO. Cross-port order follows grant order.
//  Tags are passed through unchecked.
// STRUCTURE
//  calc2_pkg: cmd_e (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6),
//    resp_e (RSP_NONE=0, RSP_OK=1, RSP_ERR=2), req_entry_t {cmd, op1, op2, tag, err}.
//  Sub-module calc2_req_fifo (one per port, generate loop): sync FIFO of req_entry_t
//    with full/empty flags.
//  Capture FSMs, rr arbiter and response register live in this module.
// TESTING
//  1 Port0 cmd=1 op1=0x30 tag=1, then op2=0x20; ALU ready; ALU returns 0x50
//    -> alu_req_valid at T+2 with op1=0x30, op2=0x20; out_resp1=1, data=0x50, tag=1 next cycle.
//  2 All 4 ports issue cmd=1 in the same cycle, ready=1 -> grants ports 0,1,2,3 on consecutive cycles;
//    repeat -> rr resumes at port 0.
//  3 Port2 sends 5 requests while alu_req_ready=0 -> 5th gets drop_pulse[2]=1;
//    after ready, exactly 4 issued in order.
//  4 Port1 cmd=3 -> no ALU issue; out_resp2=2, data=0, tag echoed.
//    Retry case: same-cycle alu_rsp to port1 -> ALU rsp first, error next cycle.
//  5 Hold alu_req_ready=0 for 3 cycles with valid=1 -> alu_req_* stable, no pop;
//    ready=1 -> single pop.
//  6 Assert reset_n=0 mid-OP2 with entries queued -> all outputs 0 immediately;
//    after release no stale issue.

Source files
------------

// File: rtl/calc2_pkg.sv
// Shared types for the calc2 request scheduler: command and response codes,
// capture FSM states and the queued request entry.
package calc2_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_OK   = 2'd1,
    RSP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
    logic        err;
  } req_entry_t;

  // A command the ALU does not implement is answered locally with an error
  function automatic logic cmd_is_err(input logic [3:0] cmd);
    return !((cmd == CMD_ADD) || (cmd == CMD_SUB) ||
             (cmd == CMD_SHL) || (cmd == CMD_SHR));
  endfunction

endpackage

// File: rtl/calc2_req_fifo.sv
// Per-port synchronous request FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise the caller reports a drop.
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       c_clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  req_entry_t wdata,
  output req_entry_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  req_entry_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_write;
  logic           do_read;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_read  = pop && !empty;
  assign do_write = push && (!full || do_read);
  assign rdata    = mem[rd_ptr[AW-1:0]];

  // Read/write pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge c_clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/calc2_req_sched.sv
// Front-end scheduler for the calc2 shared ALU: captures two-cycle requests per
// port, queues them, grants the ALU round-robin and routes results back.
module calc2_req_sched
  import calc2_pkg::*;
#(
  parameter int NPORTS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    c_clk,
  input  logic                    reset_n,
  input  logic [NPORTS-1:0][3:0]  req_cmd_in,
  input  logic [NPORTS-1:0][31:0] req_data_in,
  input  logic [NPORTS-1:0][1:0]  req_tag_in,
  output logic                    alu_req_valid,
  input  logic                    alu_req_ready,
  output logic [3:0]              alu_req_cmd,
  output logic [31:0]             alu_req_op1,
  output logic [31:0]             alu_req_op2,
  output logic [1:0]              alu_req_port,
  output logic [1:0]              alu_req_tag,
  input  logic                    alu_rsp_valid,
  input  logic [1:0]              alu_rsp_port,
  input  logic [1:0]              alu_rsp_tag,
  input  logic [1:0]              alu_rsp_resp,
  input  logic [31:0]             alu_rsp_data,
  output logic [NPORTS-1:0][1:0]  out_resp,
  output logic [NPORTS-1:0][31:0] out_data,
  output logic [NPORTS-1:0][1:0]  out_tag,
  output logic [NPORTS-1:0]       drop_pulse
);

  cap_state_e  cap_state [NPORTS];
  cap_state_e  cap_next  [NPORTS];
  logic [3:0]  lat_cmd   [NPORTS];
  logic [31:0] lat_op1   [NPORTS];
  logic [1:0]  lat_tag   [NPORTS];
  req_entry_t  wr_entry  [NPORTS];
  req_entry_t  head      [NPORTS];

  logic [NPORTS-1:0] push_vec, pop_vec, full_vec, empty_vec;

  logic [1:0]  rr_ptr, arb_port, cand, grant, hold_port;
  logic        arb_found, have_grant, hold_valid;
  logic        issue_pop, err_pop, err_blocked;
  req_entry_t  grant_head;

  logic [NPORTS-1:0][1:0]  resp_next;
  logic [NPORTS-1:0][31:0] data_next;
  logic [NPORTS-1:0][1:0]  tag_next;

  // Capture state plus the cmd/op1/tag held from the command cycle
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NPORTS; p++) begin
        cap_state[p] <= CAP_IDLE;
        lat_cmd[p]   <= '0;
        lat_op1[p]   <= '0;
        lat_tag[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        cap_state[p] <= cap_next[p];
        if ((cap_state[p] == CAP_IDLE) && (req_cmd_in[p] != 4'd0)) begin
          lat_cmd[p] <= req_cmd_in[p];
          lat_op1[p] <= req_data_in[p];
          lat_tag[p] <= req_tag_in[p];
        end
      end
    end
  end

  // Next capture state; the op2 cycle pushes the assembled entry
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      cap_next[p] = cap_state[p];
      push_vec[p] = 1'b0;
      wr_entry[p] = '0;
      case (cap_state[p])
        CAP_IDLE: if (req_cmd_in[p] != 4'd0) cap_next[p] = CAP_OP2;
        CAP_OP2: begin
          cap_next[p]     = CAP_IDLE;
          push_vec[p]     = 1'b1;
          wr_entry[p].cmd = lat_cmd[p];
          wr_entry[p].op1 = lat_op1[p];
          wr_entry[p].op2 = req_data_in[p];
          wr_entry[p].tag = lat_tag[p];
          wr_entry[p].err = cmd_is_err(lat_cmd[p]);
        end
        default: cap_next[p] = CAP_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    calc2_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .c_clk   (c_clk),
      .reset_n (reset_n),
      .push    (push_vec[p]),
      .pop     (pop_vec[p]),
      .wdata   (wr_entry[p]),
      .rdata   (head[p]),
      .full    (full_vec[p]),
      .empty   (empty_vec[p])
    );
  end

  // A write into a full FIFO survives only if that port pops in the same cycle
  assign drop_pulse = push_vec & full_vec & ~pop_vec;

  // Round-robin search: first non-empty port at or after rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_port  = rr_ptr;
    cand      = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = 2'((int'(rr_ptr) + k) % NPORTS);
      if (!arb_found && !empty_vec[cand]) begin
        arb_found = 1'b1;
        arb_port  = cand;
      end
    end
  end

  // A stalled issue keeps its grant so the ALU sees stable request fields
  assign have_grant    = hold_valid | arb_found;
  assign grant         = hold_valid ? hold_port : arb_port;
  assign grant_head    = head[grant];
  assign alu_req_valid = have_grant && !grant_head.err;
  assign err_blocked   = alu_rsp_valid && (alu_rsp_port == grant);
  assign issue_pop     = alu_req_valid && alu_req_ready;
  assign err_pop       = have_grant && grant_head.err && !err_blocked;

  assign alu_req_cmd  = alu_req_valid ? grant_head.cmd : '0;
  assign alu_req_op1  = alu_req_valid ? grant_head.op1 : '0;
  assign alu_req_op2  = alu_req_valid ? grant_head.op2 : '0;
  assign alu_req_tag  = alu_req_valid ? grant_head.tag : '0;
  assign alu_req_port = alu_req_valid ? grant : '0;

  // Route the pop to the granted port only
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      pop_vec[p] = (issue_pop || err_pop) && (grant == 2'(p));
    end
  end

  // Rotate past the served port on every pop; remember a stalled grant
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      hold_valid <= 1'b0;
      hold_port  <= '0;
    end else begin
      if (issue_pop || err_pop) rr_ptr <= 2'((int'(grant) + 1) % NPORTS);
      hold_valid <= alu_req_valid && !alu_req_ready;
      hold_port  <= grant;
    end
  end

  // One-cycle response: ALU result or a locally generated error, never both on one port
  always_comb begin
    resp_next = '0;
    data_next = '0;
    tag_next  = '0;
    if (alu_rsp_valid) begin
      resp_next[alu_rsp_port] = alu_rsp_resp;
      data_next[alu_rsp_port] = alu_rsp_data;
      tag_next[alu_rsp_port]  = alu_rsp_tag;
    end
    if (err_pop) begin
      resp_next[grant] = RSP_ERR;
      data_next[grant] = '0;
      tag_next[grant]  = grant_head.tag;
    end
  end

  // Response output registers
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      out_resp <= resp_next;
      out_data <= data_next;
      out_tag  <= tag_next;
    end
  end

endmodule

// File: tb/tb_calc2_req_sched.sv
// Self-checking bench for calc2_req_sched: directed scenarios against fixed
// expectations plus random traffic against a queue-based reference model.
module tb_calc2_req_sched;
  import calc2_pkg::*;

  localparam int NP    = 4;
  localparam int DEPTH = 4;

  logic                c_clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [NP-1:0][3:0]  req_cmd_in;
  logic [NP-1:0][31:0] req_data_in;
  logic [NP-1:0][1:0]  req_tag_in;
  logic                alu_req_valid;
  logic                alu_req_ready;
  logic [3:0]          alu_req_cmd;
  logic [31:0]         alu_req_op1;
  logic [31:0]         alu_req_op2;
  logic [1:0]          alu_req_port;
  logic [1:0]          alu_req_tag;
  logic                alu_rsp_valid;
  logic [1:0]          alu_rsp_port;
  logic [1:0]          alu_rsp_tag;
  logic [1:0]          alu_rsp_resp;
  logic [31:0]         alu_rsp_data;
  logic [NP-1:0][1:0]  out_resp;
  logic [NP-1:0][31:0] out_data;
  logic [NP-1:0][1:0]  out_tag;
  logic [NP-1:0]       drop_pulse;

  int checks = 0;
  int errors = 0;

  calc2_req_sched #(.NPORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .c_clk         (c_clk),
    .reset_n       (reset_n),
    .req_cmd_in    (req_cmd_in),
    .req_data_in   (req_data_in),
    .req_tag_in    (req_tag_in),
    .alu_req_valid (alu_req_valid),
    .alu_req_ready (alu_req_ready),
    .alu_req_cmd   (alu_req_cmd),
    .alu_req_op1   (alu_req_op1),
    .alu_req_op2   (alu_req_op2),
    .alu_req_port  (alu_req_port),
    .alu_req_tag   (alu_req_tag),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_rsp_port  (alu_rsp_port),
    .alu_rsp_tag   (alu_rsp_tag),
    .alu_rsp_resp  (alu_rsp_resp),
    .alu_rsp_data  (alu_rsp_data),
    .out_resp      (out_resp),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .drop_pulse    (drop_pulse)
  );

  always #5 c_clk = ~c_clk;

  // Reference model: per-port request queues, a pending half-request per port,
  // the round-robin start point and the port whose issue is stalled.
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
    bit          err;
  } m_req_t;

  m_req_t      mq [NP][$];
  bit          pend [NP];
  logic [3:0]  pcmd [NP];
  logic [31:0] pop1 [NP];
  logic [1:0]  ptag [NP];
  int          rr;
  bit          locked;
  int          lport;
  logic [1:0]  m_resp [NP];
  logic [31:0] m_data [NP];
  logic [1:0]  m_tag  [NP];

  logic [3:0]  cmd_tbl [4] = '{4'd1, 4'd2, 4'd5, 4'd6};

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      pend[p]   = 1'b0;
      pcmd[p]   = '0;
      pop1[p]   = '0;
      ptag[p]   = '0;
      m_resp[p] = '0;
      m_data[p] = '0;
      m_tag[p]  = '0;
    end
    rr     = 0;
    locked = 1'b0;
    lport  = 0;
  endfunction

  function automatic int m_grant();
    if (locked) return lport;
    for (int k = 0; k < NP; k++) begin
      if (mq[(rr + k) % NP].size() != 0) return (rr + k) % NP;
    end
    return -1;
  endfunction

  function automatic bit m_pops(int p);
    int g;
    g = m_grant();
    if (g != p) return 1'b0;
    if (!mq[g][0].err) return alu_req_ready;
    return !(alu_rsp_valid && (int'(alu_rsp_port) == g));
  endfunction

  task automatic model_step();
    int     g;
    bit     pops [NP];
    bit     herr;
    logic [1:0] htag;
    m_req_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    g    = m_grant();
    herr = 1'b0;
    htag = '0;
    if (g >= 0) begin
      herr = mq[g][0].err;
      htag = mq[g][0].tag;
    end
    for (int p = 0; p < NP; p++) pops[p] = m_pops(p);
    for (int p = 0; p < NP; p++) begin
      m_resp[p] = '0;
      m_data[p] = '0;
      m_tag[p]  = '0;
    end
    if (alu_rsp_valid) begin
      m_resp[alu_rsp_port] = alu_rsp_resp;
      m_data[alu_rsp_port] = alu_rsp_data;
      m_tag[alu_rsp_port]  = alu_rsp_tag;
    end
    if ((g >= 0) && herr && pops[g]) begin
      m_resp[g] = 2'd2;
      m_data[g] = '0;
      m_tag[g]  = htag;
    end
    locked = (g >= 0) && !herr && !alu_req_ready;
    lport  = (g >= 0) ? g : 0;
    if ((g >= 0) && pops[g]) begin
      void'(mq[g].pop_front());
      rr = (g + 1) % NP;
    end
    for (int p = 0; p < NP; p++) begin
      if (pend[p]) begin
        if (mq[p].size() < DEPTH) begin
          e.cmd = pcmd[p];
          e.op1 = pop1[p];
          e.op2 = req_data_in[p];
          e.tag = ptag[p];
          e.err = !(pcmd[p] inside {4'd1, 4'd2, 4'd5, 4'd6});
          mq[p].push_back(e);
        end
        pend[p] = 1'b0;
      end else if (req_cmd_in[p] != 4'd0) begin
        pend[p] = 1'b1;
        pcmd[p] = req_cmd_in[p];
        pop1[p] = req_data_in[p];
        ptag[p] = req_tag_in[p];
      end
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    req_cmd_in    = '0;
    req_data_in   = '0;
    req_tag_in    = '0;
    alu_req_ready = 1'b0;
    alu_rsp_valid = 1'b0;
    alu_rsp_port  = '0;
    alu_rsp_tag   = '0;
    alu_rsp_resp  = '0;
    alu_rsp_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge c_clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({alu_req_valid, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req: got valid=%b cmd=%h op1=%h expected all 0", alu_req_valid, alu_req_cmd, alu_req_op1);
    end
    checks++;
    if ({out_resp, out_data, out_tag, drop_pulse} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: got resp=%h drop=%h expected 0", out_resp, drop_pulse);
    end
    req_cmd_in = {4'd1, 4'd1, 4'd1, 4'd1};
    alu_rsp_valid = 1'b1;
    alu_rsp_resp  = 2'd1;
    repeat (2) @(posedge c_clk);
    @(negedge c_clk);
    checks++;
    if ({alu_req_valid, out_resp, drop_pulse} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_held: got valid=%b resp=%h drop=%h expected 0", alu_req_valid, out_resp, drop_pulse);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    alu_req_ready  = 1'b1;
    req_cmd_in[0]  = 4'd1;
    req_data_in[0] = 32'h30;
    req_tag_in[0]  = 2'd1;
    tick();
    req_cmd_in[0]  = 4'd0;
    req_data_in[0] = 32'h20;
    req_tag_in[0]  = 2'd0;
    @(negedge c_clk);
    checks++;
    if (alu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early: got valid=%b expected 0", alu_req_valid);
    end
    tick();
    req_data_in[0] = '0;
    @(negedge c_clk);
    checks++;
    if ({alu_req_valid, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag} !==
        {1'b1, 4'd1, 32'h30, 32'h20, 2'd0, 2'd1}) begin
      errors++;
      $display("[TB] FAIL single_issue: got v=%b cmd=%h op1=%h op2=%h port=%0d tag=%0d expected 1/1/30/20/0/1",
               alu_req_valid, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag);
    end
    tick();
    alu_rsp_valid = 1'b1;
    alu_rsp_port  = 2'd0;
    alu_rsp_tag   = 2'd1;
    alu_rsp_resp  = 2'd1;
    alu_rsp_data  = 32'h50;
    @(negedge c_clk);
    checks++;
    if ({alu_req_valid, out_resp} !== '0) begin
      errors++;
      $display("[TB] FAIL single_after_pop: got valid=%b resp=%h expected 0", alu_req_valid, out_resp);
    end
    tick();
    alu_rsp_valid = 1'b0;
    @(negedge c_clk);
    checks++;
    if ({out_resp[0], out_data[0], out_tag[0]} !== {2'd1, 32'h50, 2'd1}) begin
      errors++;
      $display("[TB] FAIL single_resp: got resp=%0d data=%h tag=%0d expected 1/50/1", out_resp[0], out_data[0], out_tag[0]);
    end
    checks++;
    if ({out_resp[3:1], out_data[3:1], out_tag[3:1]} !== '0) begin
      errors++;
      $display("[TB] FAIL single_other_ports: got resp=%h expected 0", out_resp);
    end
    tick();
    @(negedge c_clk);
    checks++;
    if (out_resp !== '0) begin
      errors++;
      $display("[TB] FAIL single_resp_pulse: got resp=%h expected 0", out_resp);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    alu_req_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < NP; p++) begin
        req_cmd_in[p]  = 4'd1;
        req_data_in[p] = 32'h1000 * rep + 32'(p);
        req_tag_in[p]  = 2'(p);
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        req_cmd_in[p]  = 4'd0;
        req_data_in[p] = 32'h77;
      end
      tick();
      req_data_in = '0;
      for (int k = 0; k < NP; k++) begin
        @(negedge c_clk);
        checks++;
        if ({alu_req_valid, alu_req_port, alu_req_op1} !== {1'b1, 2'(k), 32'h1000 * rep + 32'(k)}) begin
          errors++;
          $display("[TB] FAIL rr_grant rep %0d slot %0d: got v=%b port=%0d op1=%h expected port %0d",
                   rep, k, alu_req_valid, alu_req_port, alu_req_op1, k);
        end
        tick();
      end
    end
    @(negedge c_clk);
    checks++;
    if (alu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_drained: got valid=%b expected 0", alu_req_valid);
    end
  endtask

  task automatic test_fifo_full_drop();
    do_reset();
    alu_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_cmd_in[2]  = 4'd2;
      req_data_in[2] = 32'h100 + 32'(i);
      req_tag_in[2]  = 2'(i);
      tick();
      req_cmd_in[2]  = 4'd0;
      req_data_in[2] = 32'h200 + 32'(i);
      @(negedge c_clk);
      checks++;
      if (drop_pulse !== ((i == 4) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL full_drop req %0d: got drop=%b expected %b", i, drop_pulse, (i == 4) ? 4'b0100 : 4'b0000);
      end
      tick();
    end
    idle_inputs();
    alu_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge c_clk);
      checks++;
      if ({alu_req_valid, alu_req_port, alu_req_op1, alu_req_op2, alu_req_tag} !==
          {1'b1, 2'd2, 32'h100 + 32'(i), 32'h200 + 32'(i), 2'(i)}) begin
        errors++;
        $display("[TB] FAIL full_order %0d: got v=%b port=%0d op1=%h op2=%h expected port 2 op1=%h",
                 i, alu_req_valid, alu_req_port, alu_req_op1, alu_req_op2, 32'h100 + 32'(i));
      end
      tick();
    end
    @(negedge c_clk);
    checks++;
    if (alu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_count: got valid=%b after 4 issues expected 0", alu_req_valid);
    end
  endtask

  task automatic test_error_entry();
    do_reset();
    alu_req_ready  = 1'b1;
    req_cmd_in[1]  = 4'd3;
    req_data_in[1] = 32'h77;
    req_tag_in[1]  = 2'd2;
    tick();
    req_cmd_in[1]  = 4'd0;
    req_data_in[1] = 32'h99;
    tick();
    req_data_in[1] = '0;
    @(negedge c_clk);
    checks++;
    if (alu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_no_issue: got valid=%b expected 0", alu_req_valid);
    end
    tick();
    @(negedge c_clk);
    checks++;
    if ({out_resp[1], out_data[1], out_tag[1]} !== {2'd2, 32'd0, 2'd2}) begin
      errors++;
      $display("[TB] FAIL err_resp: got resp=%0d data=%h tag=%0d expected 2/0/2", out_resp[1], out_data[1], out_tag[1]);
    end
    tick();
    req_cmd_in[1]  = 4'd7;
    req_data_in[1] = 32'h1;
    req_tag_in[1]  = 2'd3;
    tick();
    req_cmd_in[1]  = 4'd0;
    req_data_in[1] = 32'h2;
    tick();
    req_data_in[1] = '0;
    alu_rsp_valid  = 1'b1;
    alu_rsp_port   = 2'd1;
    alu_rsp_tag    = 2'd0;
    alu_rsp_resp   = 2'd1;
    alu_rsp_data   = 32'hABCD;
    tick();
    alu_rsp_valid  = 1'b0;
    @(negedge c_clk);
    checks++;
    if ({out_resp[1], out_data[1], out_tag[1]} !== {2'd1, 32'hABCD, 2'd0}) begin
      errors++;
      $display("[TB] FAIL err_retry_alu_first: got resp=%0d data=%h tag=%0d expected 1/abcd/0", out_resp[1], out_data[1], out_tag[1]);
    end
    tick();
    @(negedge c_clk);
    checks++;
    if ({out_resp[1], out_data[1], out_tag[1]} !== {2'd2, 32'd0, 2'd3}) begin
      errors++;
      $display("[TB] FAIL err_retry_err_next: got resp=%0d data=%h tag=%0d expected 2/0/3", out_resp[1], out_data[1], out_tag[1]);
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    alu_req_ready  = 1'b0;
    req_cmd_in[3]  = 4'd2;
    req_data_in[3] = 32'd5;
    req_tag_in[3]  = 2'd1;
    tick();
    req_cmd_in[3]  = 4'd0;
    req_data_in[3] = 32'd3;
    req_cmd_in[0]  = 4'd1;
    req_data_in[0] = 32'h44;
    req_tag_in[0]  = 2'd0;
    tick();
    req_cmd_in[0]  = 4'd0;
    req_data_in[0] = 32'h55;
    req_data_in[3] = '0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) alu_req_ready = 1'b1;
      @(negedge c_clk);
      checks++;
      if ({alu_req_valid, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag} !==
          {1'b1, 4'd2, 32'd5, 32'd3, 2'd3, 2'd1}) begin
        errors++;
        $display("[TB] FAIL stall_stable cycle %0d: got v=%b cmd=%h op1=%h op2=%h port=%0d tag=%0d expected port 3 op1=5 op2=3",
                 c, alu_req_valid, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag);
      end
      tick();
      req_data_in[0] = '0;
    end
    @(negedge c_clk);
    checks++;
    if ({alu_req_valid, alu_req_port, alu_req_op1, alu_req_op2} !== {1'b1, 2'd0, 32'h44, 32'h55}) begin
      errors++;
      $display("[TB] FAIL stall_single_pop: got v=%b port=%0d op1=%h expected port 0 op1=44", alu_req_valid, alu_req_port, alu_req_op1);
    end
    tick();
    @(negedge c_clk);
    checks++;
    if (alu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_drained: got valid=%b expected 0", alu_req_valid);
    end
  endtask

  task automatic test_random();
    int         g;
    bit         ev;
    logic [NP-1:0] exp_drop;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: req_cmd_in[p] = 4'd0;
          9:          req_cmd_in[p] = 4'($urandom_range(0, 15));
          default:    req_cmd_in[p] = cmd_tbl[$urandom_range(0, 3)];
        endcase
        req_data_in[p] = $urandom();
        req_tag_in[p]  = 2'($urandom_range(0, 3));
      end
      alu_req_ready = ($urandom_range(0, 9) < 6);
      alu_rsp_valid = ($urandom_range(0, 9) < 3);
      alu_rsp_port  = 2'($urandom_range(0, 3));
      alu_rsp_tag   = 2'($urandom_range(0, 3));
      alu_rsp_resp  = 2'($urandom_range(1, 2));
      alu_rsp_data  = $urandom();
      @(negedge c_clk);
      g  = m_grant();
      ev = (g >= 0) && !mq[g][0].err;
      checks++;
      if (alu_req_valid !== ev) begin
        errors++;
        $display("[TB] FAIL rand_valid cycle %0d: got %b expected %b", c, alu_req_valid, ev);
      end
      if (ev) begin
        checks++;
        if ({alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag} !==
            {mq[g][0].cmd, mq[g][0].op1, mq[g][0].op2, 2'(g), mq[g][0].tag}) begin
          errors++;
          $display("[TB] FAIL rand_fields cycle %0d: got port=%0d cmd=%h op1=%h op2=%h expected port=%0d cmd=%h op1=%h op2=%h",
                   c, alu_req_port, alu_req_cmd, alu_req_op1, alu_req_op2, g, mq[g][0].cmd, mq[g][0].op1, mq[g][0].op2);
        end
      end
      for (int p = 0; p < NP; p++) begin
        exp_drop[p] = pend[p] && (mq[p].size() == DEPTH) && !m_pops(p);
      end
      checks++;
      if (drop_pulse !== exp_drop) begin
        errors++;
        $display("[TB] FAIL rand_drop cycle %0d: got %b expected %b", c, drop_pulse, exp_drop);
      end
      for (int p = 0; p < NP; p++) begin
        checks++;
        if ({out_resp[p], out_data[p], out_tag[p]} !== {m_resp[p], m_data[p], m_tag[p]}) begin
          errors++;
          $display("[TB] FAIL rand_out port %0d cycle %0d: got %0d/%h/%0d expected %0d/%h/%0d",
                   p, c, out_resp[p], out_data[p], out_tag[p], m_resp[p], m_data[p], m_tag[p]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    alu_req_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req_cmd_in[p]  = 4'd1;
      req_data_in[p] = 32'hA0 + 32'(p);
    end
    tick();
    req_cmd_in  = '0;
    req_data_in = {32'h0, 32'h0, 32'hB1, 32'hB0};
    tick();
    req_cmd_in[2]  = 4'd5;
    req_data_in    = '0;
    req_data_in[2] = 32'hC0;
    tick();
    req_cmd_in[2]  = 4'd0;
    req_data_in[2] = 32'hC1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({alu_req_valid, alu_req_cmd, alu_req_op1, alu_req_op2, alu_req_port, alu_req_tag,
         out_resp, out_data, out_tag, drop_pulse} !== '0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: got valid=%b resp=%h drop=%b expected all 0", alu_req_valid, out_resp, drop_pulse);
    end
    idle_inputs();
    tick();
    reset_n = 1'b1;
    alu_req_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge c_clk);
      checks++;
      if ({alu_req_valid, out_resp, drop_pulse} !== '0) begin
        errors++;
        $display("[TB] FAIL midflight_stale cycle %0d: got valid=%b port=%0d resp=%h expected 0", c, alu_req_valid, alu_req_port, out_resp);
      end
      tick();
    end
    req_cmd_in[3]  = 4'd6;
    req_data_in[3] = 32'hD0;
    req_tag_in[3]  = 2'd2;
    tick();
    req_cmd_in[3]  = 4'd0;
    req_data_in[3] = 32'hD1;
    tick();
    req_data_in[3] = '0;
    @(negedge c_clk);
    checks++;
    if ({alu_req_valid, alu_req_port, alu_req_cmd, alu_req_op1, alu_req_op2} !== {1'b1, 2'd3, 4'd6, 32'hD0, 32'hD1}) begin
      errors++;
      $display("[TB] FAIL midflight_fresh: got v=%b port=%0d op1=%h expected port 3 op1=d0", alu_req_valid, alu_req_port, alu_req_op1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full_drop();
    test_error_entry();
    test_stall_hold();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
